// File: rtl/wb_arbiter_pkg.sv
// Shared register-file widths and constants for the writeback arbiter slice.
package wb_arbiter_pkg;

    // Register file geometry
    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    // Frequently used constants
    localparam logic [RegAddrBus-1:0] ZeroRegAddr  = '0;
    localparam logic                  WriteEnable  = 1'b1;
    localparam logic                  WriteDisable = 1'b0;
    localparam logic                  RstEnable    = 1'b0;
    localparam logic [RegBus-1:0]     ZeroWord     = '0;

    // Which requester owns the write port this cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_REQ0 = 2'd1,
        GNT_REQ1 = 2'd2
    } grant_e;

    // One regfile write: destination and payload
    typedef struct packed {
        logic [RegAddrBus-1:0] addr;
        logic [RegBus-1:0]     data;
    } wb_wr_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register that is
// waiting on a requester-1 (long-latency) writeback.
module wb_scoreboard
    import wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  set_i,
    input  logic [RegAddrBus-1:0] set_addr_i,
    input  logic                  clr_i,
    input  logic [RegAddrBus-1:0] clr_addr_i,
    input  logic [RegAddrBus-1:0] rs1_addr_i,
    input  logic                  rs1_read_i,
    input  logic [RegAddrBus-1:0] rs2_addr_i,
    input  logic                  rs2_read_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o
);

    logic [RegBus-1:0] busy_q;
    logic [RegBus-1:0] busy_d;
    logic [RegBus-1:0] set_mask;
    logic [RegBus-1:0] clr_mask;

    // Next busy vector: clear first, then OR in the set so a same-address
    // set/clear leaves the register busy; x0 can never become busy.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_i && (set_addr_i != ZeroRegAddr)) begin
            set_mask[set_addr_i] = 1'b1;
        end
        if (clr_i) begin
            clr_mask[clr_addr_i] = 1'b1;
        end
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    // Busy vector register, wiped by reset
    always_ff @(posedge clk or negedge rstn) begin
        if (rstn == RstEnable) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Hazard lookups use the pre-update vector
    assign rs1_busy_o = rs1_read_i & busy_q[rs1_addr_i];
    assign rs2_busy_o = rs2_read_i & busy_q[rs2_addr_i];

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester regfile writeback arbiter. Requester 0 (single-cycle ALU)
// normally has priority; requester 1 (div/load) is promoted after losing
// STARVE_LIMIT consecutive arbitrations. The winning write is registered
// for one cycle before reaching the regfile port.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req0_valid_i,
    input  logic [RegAddrBus-1:0] req0_addr_i,
    input  logic [RegBus-1:0]     req0_data_i,
    output logic                  req0_ready_o,
    input  logic                  req1_valid_i,
    input  logic [RegAddrBus-1:0] req1_addr_i,
    input  logic [RegBus-1:0]     req1_data_i,
    output logic                  req1_ready_o,
    input  logic                  issue_i,
    input  logic [RegAddrBus-1:0] issue_addr_i,
    input  logic [RegAddrBus-1:0] rs1_addr_i,
    input  logic [RegAddrBus-1:0] rs2_addr_i,
    input  logic                  rs1_read_i,
    input  logic                  rs2_read_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    output logic                  wen_o,
    output logic [RegAddrBus-1:0] wr_addr_o,
    output logic [RegBus-1:0]     wr_data_o
);

    // Two-bit counter that sticks at its maximum instead of wrapping
    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'd1;
    endfunction

    logic [1:0] starve_cnt;
    logic       starve_hit;
    grant_e     grant_sel;
    logic       vld_p0;
    wb_wr_t     wr_p0;
    logic       vld_p1;
    wb_wr_t     wr_p1;

    assign starve_hit = (int'(starve_cnt) >= STARVE_LIMIT);

    // Grant selection: a lone requester wins; on contention req0 wins
    // unless req1 has been starved long enough.
    always_comb begin
        grant_sel = GNT_NONE;
        if (req0_valid_i && req1_valid_i) begin
            grant_sel = starve_hit ? GNT_REQ1 : GNT_REQ0;
        end else if (req0_valid_i) begin
            grant_sel = GNT_REQ0;
        end else if (req1_valid_i) begin
            grant_sel = GNT_REQ1;
        end
    end

    // Handshakes are held low throughout reset
    assign req0_ready_o = rstn & (grant_sel == GNT_REQ0);
    assign req1_ready_o = rstn & (grant_sel == GNT_REQ1);

    // ---- stage p0: mux the winning write ----
    always_comb begin
        vld_p0  = 1'b0;
        wr_p0   = '{addr: ZeroRegAddr, data: ZeroWord};
        unique case (grant_sel)
            GNT_REQ0: begin
                vld_p0  = 1'b1;
                wr_p0   = '{addr: req0_addr_i, data: req0_data_i};
            end
            GNT_REQ1: begin
                vld_p0  = 1'b1;
                wr_p0   = '{addr: req1_addr_i, data: req1_data_i};
            end
            default: begin
                vld_p0  = 1'b0;
            end
        endcase
    end

    // Starvation counter: counts consecutive cycles req1 waits while valid
    always_ff @(posedge clk or negedge rstn) begin
        if (rstn == RstEnable) begin
            starve_cnt <= 2'd0;
        end else if (req1_valid_i && (grant_sel != GNT_REQ1)) begin
            starve_cnt <= sat_inc2(starve_cnt);
        end else begin
            starve_cnt <= 2'd0;
        end
    end

    // ---- stage p1: registered regfile write port ----
    // Writes to x0 complete the handshake but never raise the enable;
    // address and data hold their last value on idle cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (rstn == RstEnable) begin
            vld_p1 <= WriteDisable;
            wr_p1  <= '{addr: ZeroRegAddr, data: ZeroWord};
        end else if (vld_p0) begin
            vld_p1 <= (wr_p0.addr != ZeroRegAddr) ? WriteEnable : WriteDisable;
            wr_p1  <= wr_p0;
        end else begin
            vld_p1 <= WriteDisable;
        end
    end

    assign wen_o     = vld_p1;
    assign wr_addr_o = wr_p1.addr;
    assign wr_data_o = wr_p1.data;

    // Scoreboard: issues mark destinations busy, req1 writebacks release them
    wb_scoreboard u_scoreboard (
        .clk        (clk),
        .rstn       (rstn),
        .set_i      (issue_i),
        .set_addr_i (issue_addr_i),
        .clr_i      (grant_sel == GNT_REQ1),
        .clr_addr_i (req1_addr_i),
        .rs1_addr_i (rs1_addr_i),
        .rs1_read_i (rs1_read_i),
        .rs2_addr_i (rs2_addr_i),
        .rs2_read_i (rs2_read_i),
        .rs1_busy_o (rs1_busy_o),
        .rs2_busy_o (rs2_busy_o)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed + randomized bench for wb_arbiter against a behavioural model.
module tb_wb_arbiter;

    localparam int LIMIT = 3;

    logic        clk;
    logic        rstn;
    logic        req0_valid_i, req1_valid_i;
    logic [4:0]  req0_addr_i, req1_addr_i;
    logic [31:0] req0_data_i, req1_data_i;
    logic        req0_ready_o, req1_ready_o;
    logic        issue_i;
    logic [4:0]  issue_addr_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i;
    logic        rs1_read_i, rs2_read_i;
    logic        rs1_busy_o, rs2_busy_o;
    logic        wen_o;
    logic [4:0]  wr_addr_o;
    logic [31:0] wr_data_o;

    wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req0_valid_i (req0_valid_i),
        .req0_addr_i  (req0_addr_i),
        .req0_data_i  (req0_data_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_addr_i  (req1_addr_i),
        .req1_data_i  (req1_data_i),
        .req1_ready_o (req1_ready_o),
        .issue_i      (issue_i),
        .issue_addr_i (issue_addr_i),
        .rs1_addr_i   (rs1_addr_i),
        .rs2_addr_i   (rs2_addr_i),
        .rs1_read_i   (rs1_read_i),
        .rs2_read_i   (rs2_read_i),
        .rs1_busy_o   (rs1_busy_o),
        .rs2_busy_o   (rs2_busy_o),
        .wen_o        (wen_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit          m_busy [32];
    int          m_starve;
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_g0, m_g1;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_starve = 0;
        m_wen    = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
        m_g0     = 1'b0;
        m_g1     = 1'b0;
    endtask

    // Who should win given the present inputs
    task automatic model_grant();
        m_g0 = 1'b0;
        m_g1 = 1'b0;
        if (rstn) begin
            if (req0_valid_i && req1_valid_i) begin
                if (m_starve >= LIMIT) m_g1 = 1'b1;
                else                   m_g0 = 1'b1;
            end else begin
                m_g0 = req0_valid_i;
                m_g1 = req1_valid_i;
            end
        end
    endtask

    // One clock: check handshake/hazard outputs mid-cycle, advance the model
    // on the edge, then check the registered write port just after it.
    task automatic cycle();
        @(negedge clk);
        model_grant();
        check("req0_ready", req0_ready_o, m_g0);
        check("req1_ready", req1_ready_o, m_g1);
        check("rs1_busy", rs1_busy_o, rs1_read_i && m_busy[rs1_addr_i]);
        check("rs2_busy", rs2_busy_o, rs2_read_i && m_busy[rs2_addr_i]);
        @(posedge clk);
        if (rstn) begin
            if (req1_valid_i && !m_g1) m_starve = (m_starve < 3) ? m_starve + 1 : 3;
            else                       m_starve = 0;
            if (m_g0 || m_g1) begin
                m_waddr = m_g1 ? req1_addr_i : req0_addr_i;
                m_wdata = m_g1 ? req1_data_i : req0_data_i;
                m_wen   = (m_waddr != 5'd0);
            end else begin
                m_wen = 1'b0;
            end
            if (m_g1) m_busy[req1_addr_i] = 1'b0;
            if (issue_i && issue_addr_i != 5'd0) m_busy[issue_addr_i] = 1'b1;
        end
        #1;
        check("wen", wen_o, m_wen);
        check("wr_addr", wr_addr_o, m_waddr);
        check("wr_data", wr_data_o, m_wdata);
    endtask

    task automatic idle_inputs();
        req0_valid_i = 1'b0; req0_addr_i = '0; req0_data_i = '0;
        req1_valid_i = 1'b0; req1_addr_i = '0; req1_data_i = '0;
        issue_i = 1'b0; issue_addr_i = '0;
        rs1_addr_i = '0; rs1_read_i = 1'b0;
        rs2_addr_i = '0; rs2_read_i = 1'b0;
    endtask

    initial begin
        logic        v0, v1;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;

        model_reset();
        idle_inputs();
        rstn = 1'b0;

        // Reset: outputs quiet even with requests present
        req0_valid_i = 1'b1; req0_addr_i = 5'd4; req0_data_i = 32'h1234;
        req1_valid_i = 1'b1; req1_addr_i = 5'd6;
        issue_i = 1'b1; issue_addr_i = 5'd8;
        rs1_addr_i = 5'd8; rs1_read_i = 1'b1;
        cycle();
        check("rst_wen", wen_o, 1'b0);
        check("rst_addr", wr_addr_o, 5'd0);
        check("rst_data", wr_data_o, 32'd0);
        check("rst_ready0", req0_ready_o, 1'b0);
        check("rst_busy1", rs1_busy_o, 1'b0);
        idle_inputs();
        rstn = 1'b1;
        cycle();

        // Lone req0 write to r5
        req0_valid_i = 1'b1; req0_addr_i = 5'd5; req0_data_i = 32'h11;
        #1;
        check("r0_alone_ready", req0_ready_o, 1'b1);
        cycle();
        check("r0_alone_wen", wen_o, 1'b1);
        check("r0_alone_addr", wr_addr_o, 5'd5);
        check("r0_alone_data", wr_data_o, 32'h11);
        idle_inputs();
        cycle();
        check("idle_wen", wen_o, 1'b0);
        check("idle_hold_data", wr_data_o, 32'h11);

        // Contention: req0 wins LIMIT times, then req1, then req0 again
        for (int i = 0; i < 5; i++) begin
            req0_valid_i = 1'b1; req0_addr_i = 5'(i + 1); req0_data_i = 32'hA0 + 32'(i);
            req1_valid_i = 1'b1; req1_addr_i = 5'd20;     req1_data_i = 32'hB0 + 32'(i);
            #1;
            check("starve_ready1", req1_ready_o, (i == LIMIT));
            check("starve_ready0", req0_ready_o, (i != LIMIT));
            cycle();
        end
        idle_inputs();
        cycle();

        // Issue to r7 makes it busy until req1 writes it back
        issue_i = 1'b1; issue_addr_i = 5'd7;
        rs1_addr_i = 5'd7; rs1_read_i = 1'b1;
        cycle();
        issue_i = 1'b0;
        check("busy7_set", rs1_busy_o, 1'b1);
        cycle();
        req1_valid_i = 1'b1; req1_addr_i = 5'd7; req1_data_i = 32'h77;
        #1;
        check("busy7_during_wb", rs1_busy_o, 1'b1);
        cycle();
        req1_valid_i = 1'b0;
        check("busy7_cleared", rs1_busy_o, 1'b0);
        check("r1_wb_addr", wr_addr_o, 5'd7);
        idle_inputs();

        // Same-cycle clear and re-issue of r9: set wins
        issue_i = 1'b1; issue_addr_i = 5'd9;
        cycle();
        req1_valid_i = 1'b1; req1_addr_i = 5'd9; req1_data_i = 32'h99;
        rs2_addr_i = 5'd9; rs2_read_i = 1'b1;
        cycle();
        idle_inputs();
        rs2_addr_i = 5'd9; rs2_read_i = 1'b1;
        #1;
        check("busy9_set_wins", rs2_busy_o, 1'b1);
        // Issue to x0 never marks it busy
        issue_i = 1'b1; issue_addr_i = 5'd0;
        cycle();
        idle_inputs();
        rs1_addr_i = 5'd0; rs1_read_i = 1'b1;
        #1;
        check("x0_never_busy", rs1_busy_o, 1'b0);

        // Write to x0 handshakes but does not write
        req0_valid_i = 1'b1; req0_addr_i = 5'd0; req0_data_i = 32'hFF;
        #1;
        check("x0_ready", req0_ready_o, 1'b1);
        cycle();
        check("x0_wen", wen_o, 1'b0);
        idle_inputs();

        // Reset right after a transfer to r3 drops the pending write and busy bits
        req0_valid_i = 1'b1; req0_addr_i = 5'd3; req0_data_i = 32'hABCD;
        issue_i = 1'b1; issue_addr_i = 5'd12;
        rs1_addr_i = 5'd12; rs1_read_i = 1'b1;
        cycle();
        check("pre_rst_wen", wen_o, 1'b1);
        idle_inputs();
        rs1_addr_i = 5'd12; rs1_read_i = 1'b1;
        rstn = 1'b0;
        #1;
        model_reset();
        check("midrst_wen", wen_o, 1'b0);
        check("midrst_addr", wr_addr_o, 5'd0);
        check("midrst_data", wr_data_o, 32'd0);
        check("midrst_busy", rs1_busy_o, 1'b0);
        cycle();
        rstn = 1'b1;
        cycle();
        check("post_rst_nowrite", wen_o, 1'b0);
        cycle();

        // Randomized traffic; each requester holds its request until accepted
        v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int n = 0; n < 400; n++) begin
            if (!v0 || m_g0) begin
                v0 = ($urandom_range(0, 2) != 0);
                a0 = 5'($urandom_range(0, 7));
                d0 = $urandom;
            end
            if (!v1 || m_g1) begin
                v1 = ($urandom_range(0, 2) != 0);
                a1 = 5'($urandom_range(0, 7));
                d1 = $urandom;
            end
            req0_valid_i = v0; req0_addr_i = a0; req0_data_i = d0;
            req1_valid_i = v1; req1_addr_i = a1; req1_data_i = d1;
            issue_i      = ($urandom_range(0, 3) == 0);
            issue_addr_i = 5'($urandom_range(0, 7));
            rs1_addr_i   = 5'($urandom_range(0, 7));
            rs2_addr_i   = 5'($urandom_range(0, 7));
            rs1_read_i   = 1'($urandom_range(0, 1));
            rs2_read_i   = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
